// File: rtl/xilinx_pcie_tx_engine.sv
// rtl/xilinx_pcie_tx_engine.sv - PCIe 128-bit AXIS TX TLP builder: PIO completions arbitrated against split DMA reads
//
// Purpose:
//   Builds single-beat TLPs for the Xilinx 128-bit AXIS TX port.
//   Completions (Cpl/CplD) for PIO reads share the port with DMA memory read
//   requests. DMA descriptors are split into MRRS-aligned MRd32/MRd64 chunks,
//   and each chunk takes one tag from a pool of P_NUM_TAGS tags.
//
// Configuration macro:
//   PCIE_TX_RR_ARB_EN
//     Defined:   round-robin between the completion and DMA sources.
//     Undefined: completions have strict priority over DMA.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   s_axis_tx_*               AXIS TX beat to the PCIe core (tdata/tkeep/tlast/tvalid/tready)
//   tx_src_dsc                discontinue, tied low
//   completer_id              own requester/completer ID
//   dma_read_*                DMA read descriptor handshake and per-descriptor done pulse
//   tag_alloc_*               pulse with tag and DW length of each MRd sent
//   tag_release_*             completion tracker returns a tag
//   tags_in_flight            number of allocated tags
//   req_*                     PIO completion request and header fields
//   rd_addr, rd_be, rd_data   PIO read-back interface for CplD payload
//   compl_done                pulse after a completion TLP is accepted
module xilinx_pcie_tx_engine #(
    parameter int P_DATA_WIDTH = 128,
    parameter int P_KEEP_WIDTH = P_DATA_WIDTH / 8,
    parameter int P_NUM_TAGS   = 32,
    parameter int P_MRRS_BYTES = 512
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    s_axis_tx_tready,
    output logic [P_DATA_WIDTH-1:0] s_axis_tx_tdata,
    output logic [P_KEEP_WIDTH-1:0] s_axis_tx_tkeep,
    output logic                    s_axis_tx_tlast,
    output logic                    s_axis_tx_tvalid,
    output logic                    tx_src_dsc,
    input  logic [15:0]             completer_id,
    input  logic [63:0]             dma_read_addr,
    input  logic [10:0]             dma_read_len,
    input  logic                    dma_read_valid,
    output logic                    dma_read_ready,
    output logic                    dma_read_done,
    output logic                    tag_alloc_valid,
    output logic [7:0]              tag_alloc_tag,
    output logic [9:0]              tag_alloc_len,
    input  logic                    tag_release_valid,
    input  logic [7:0]              tag_release_tag,
    output logic [8:0]              tags_in_flight,
    input  logic                    req_compl,
    input  logic                    req_compl_wd,
    input  logic [2:0]              req_tc,
    input  logic                    req_td,
    input  logic                    req_ep,
    input  logic [1:0]              req_attr,
    input  logic [9:0]              req_len,
    input  logic [15:0]             req_rid,
    input  logic [7:0]              req_tag,
    input  logic [7:0]              req_be,
    input  logic [31:0]             req_addr,
    output logic [31:0]             rd_addr,
    output logic [3:0]              rd_be,
    input  logic [31:0]             rd_data,
    output logic                    compl_done
);

    localparam int LP_MRRS_LOG2 = $clog2(P_MRRS_BYTES);
    localparam int LP_MRRS_DW   = P_MRRS_BYTES / 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPLIT = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_run;
    logic [127:0]            r_tdata;
    logic [P_KEEP_WIDTH-1:0] r_tkeep;
    logic                    r_tvalid;
    logic [63:0]             r_addr;
    logic [10:0]             r_rem;
    logic                    r_cur_cpl;
    logic                    r_cur_last;
    logic [7:0]              r_cur_tag;
    logic [9:0]              r_cur_len;
    logic [P_NUM_TAGS-1:0]   r_tag_map;
    logic                    r_compl_done;
    logic                    r_tag_alloc_valid;
    logic [7:0]              r_tag_alloc_tag;
    logic [9:0]              r_tag_alloc_len;
    logic                    r_dma_read_done;
`ifdef PCIE_TX_RR_ARB_EN
    logic                    r_last_cpl;
`endif

    logic                    w_in_arb;
    logic                    w_cpl_req;
    logic                    w_hold;
    logic                    w_dma_req;
    logic                    w_dma_ok;
    logic                    w_grant_cpl;
    logic                    w_accept;
    logic                    w_alloc;
    logic                    w_tag_free;
    logic [7:0]              w_free_tag;
    logic [P_NUM_TAGS-1:0]   w_map_next;
    logic [8:0]              w_popcount;
    logic [11:0]             w_bound_dw;
    logic [11:0]             w_chunk;
    logic [63:0]             w_addr_next;
    logic                    w_is64;
    logic [31:0]             w_mrd_dw0;
    logic [31:0]             w_mrd_dw1;
    logic [127:0]            w_mrd_tdata;
    logic [15:0]             w_mrd_tkeep;
    logic [11:0]             w_byte_count;
    logic [1:0]              w_first_off;
    logic [6:0]              w_lower_addr;
    logic [127:0]            w_cpl_tdata;
    logic [15:0]             w_cpl_tkeep;
    logic                    w_unused;

    assign w_unused = ^{req_be[7:4], w_chunk[11]};

    // ---------------------------------------------------------------
    // Arbitration. req_compl is a level held until compl_done; while
    // compl_done is high and req_compl is still asserted nothing is
    // granted, so one request never produces two completions.
    // ---------------------------------------------------------------
    assign w_in_arb  = r_run && (r_state == ST_IDLE || r_state == ST_SPLIT);
    assign w_cpl_req = w_in_arb && req_compl && !r_compl_done;
    assign w_hold    = req_compl && r_compl_done;
    assign w_dma_req = (r_state == ST_IDLE && dma_read_valid) ||
                       (r_state == ST_SPLIT && w_tag_free);

`ifdef PCIE_TX_RR_ARB_EN
    assign w_dma_ok    = !w_hold && (!w_cpl_req || r_last_cpl);
    assign w_grant_cpl = w_cpl_req && !(w_dma_req && r_last_cpl);
`else
    assign w_dma_ok    = !req_compl;
    assign w_grant_cpl = w_cpl_req;
`endif

    assign dma_read_ready = r_run && (r_state == ST_IDLE) && w_dma_ok;
    assign w_accept       = dma_read_ready && dma_read_valid && !w_grant_cpl;
    assign w_alloc        = r_run && (r_state == ST_SPLIT) && w_tag_free &&
                            w_dma_ok && !w_grant_cpl;

    // ---------------------------------------------------------------
    // Tag pool: lowest free tag, next bitmap, popcount.
    // ---------------------------------------------------------------
    always_comb begin
        w_free_tag = 8'd0;
        w_tag_free = 1'b0;
        for (int i = P_NUM_TAGS - 1; i >= 0; i--) begin
            if (!r_tag_map[i]) begin
                w_free_tag = 8'(i);
                w_tag_free = 1'b1;
            end
        end
    end

    // Matching by comparison makes out-of-range releases fall through.
    always_comb begin
        w_map_next = r_tag_map;
        for (int i = 0; i < P_NUM_TAGS; i++) begin
            if (tag_release_valid && tag_release_tag == 8'(i))
                w_map_next[i] = 1'b0;
            if (w_alloc && w_free_tag == 8'(i))
                w_map_next[i] = 1'b1;
        end
    end

    always_comb begin
        w_popcount = 9'd0;
        for (int i = 0; i < P_NUM_TAGS; i++)
            w_popcount = w_popcount + 9'(r_tag_map[i]);
    end

    // ---------------------------------------------------------------
    // Chunking: stop at the next MRRS boundary (also never crosses 4KB).
    // ---------------------------------------------------------------
    assign w_bound_dw  = 12'(LP_MRRS_DW) -
                         {{(14 - LP_MRRS_LOG2){1'b0}}, r_addr[LP_MRRS_LOG2-1:2]};
    assign w_chunk     = ({1'b0, r_rem} < w_bound_dw) ? {1'b0, r_rem} : w_bound_dw;
    assign w_addr_next = r_addr + {50'd0, w_chunk, 2'b00};

    // MRd header; a 1024 DW chunk encodes as length 0 by truncation.
    assign w_is64    = |r_addr[63:32];
    assign w_mrd_dw0 = {1'b0, (w_is64 ? 2'b01 : 2'b00), 5'b00000, 1'b0, 3'b000,
                        4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, w_chunk[9:0]};
    assign w_mrd_dw1 = {completer_id, w_free_tag,
                        ((w_chunk == 12'd1) ? 4'h0 : 4'hF), 4'hF};
    assign w_mrd_tdata = w_is64 ?
        {{r_addr[31:2], 2'b00}, r_addr[63:32], w_mrd_dw1, w_mrd_dw0} :
        {32'd0, {r_addr[31:2], 2'b00}, w_mrd_dw1, w_mrd_dw0};
    assign w_mrd_tkeep = w_is64 ? 16'hFFFF : 16'h0FFF;

    // ---------------------------------------------------------------
    // Completion header.
    // ---------------------------------------------------------------
    assign rd_addr = req_addr;
    assign rd_be   = req_be[3:0];

    always_comb begin
        w_byte_count = 12'd1;
        casez (rd_be)
            4'b1??1:                   w_byte_count = 12'd4;
            4'b01?1, 4'b1?10:          w_byte_count = 12'd3;
            4'b0011, 4'b0110, 4'b1100: w_byte_count = 12'd2;
            default:                   w_byte_count = 12'd1;
        endcase
    end

    always_comb begin
        w_first_off = 2'd0;
        casez (rd_be)
            4'b???1: w_first_off = 2'd0;
            4'b??10: w_first_off = 2'd1;
            4'b?100: w_first_off = 2'd2;
            4'b1000: w_first_off = 2'd3;
            default: w_first_off = 2'd0;
        endcase
    end

    assign w_lower_addr = req_compl_wd ? {req_addr[6:2], w_first_off} : 7'd0;
    assign w_cpl_tdata  = {
        (req_compl_wd ? rd_data : 32'd0),
        {req_rid, req_tag, 1'b0, w_lower_addr},
        {completer_id, 3'b000, 1'b0, w_byte_count},
        {1'b0, (req_compl_wd ? 2'b10 : 2'b00), 5'b01010, 1'b0, req_tc, 4'b0000,
         req_td, req_ep, req_attr, 2'b00, (req_compl_wd ? req_len : 10'd0)}};
    assign w_cpl_tkeep  = req_compl_wd ? 16'hFFFF : 16'h0FFF;

    // ---------------------------------------------------------------
    // FSM with registered outputs.
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state           <= ST_IDLE;
            r_run             <= 1'b0;
            r_tdata           <= '0;
            r_tkeep           <= '0;
            r_tvalid          <= 1'b0;
            r_addr            <= '0;
            r_rem             <= '0;
            r_cur_cpl         <= 1'b0;
            r_cur_last        <= 1'b0;
            r_cur_tag         <= '0;
            r_cur_len         <= '0;
            r_tag_map         <= '0;
            r_compl_done      <= 1'b0;
            r_tag_alloc_valid <= 1'b0;
            r_tag_alloc_tag   <= '0;
            r_tag_alloc_len   <= '0;
            r_dma_read_done   <= 1'b0;
`ifdef PCIE_TX_RR_ARB_EN
            r_last_cpl        <= 1'b0;
`endif
        end else begin
            r_run             <= 1'b1;
            r_compl_done      <= 1'b0;
            r_tag_alloc_valid <= 1'b0;
            r_dma_read_done   <= 1'b0;
            r_tag_map         <= w_map_next;
            case (r_state)
                ST_IDLE, ST_SPLIT: begin
                    if (w_grant_cpl) begin
                        r_tdata   <= w_cpl_tdata;
                        r_tkeep   <= w_cpl_tkeep;
                        r_tvalid  <= 1'b1;
                        r_cur_cpl <= 1'b1;
                        r_state   <= ST_SEND;
`ifdef PCIE_TX_RR_ARB_EN
                        r_last_cpl <= 1'b1;
`endif
                    end else if (w_accept) begin
                        r_addr  <= dma_read_addr;
                        r_rem   <= dma_read_len;
                        r_state <= ST_SPLIT;
                    end else if (w_alloc) begin
                        r_tdata    <= w_mrd_tdata;
                        r_tkeep    <= w_mrd_tkeep;
                        r_tvalid   <= 1'b1;
                        r_addr     <= w_addr_next;
                        r_rem      <= r_rem - w_chunk[10:0];
                        r_cur_cpl  <= 1'b0;
                        r_cur_last <= (r_rem == w_chunk[10:0]);
                        r_cur_tag  <= w_free_tag;
                        r_cur_len  <= w_chunk[9:0];
                        r_state    <= ST_SEND;
`ifdef PCIE_TX_RR_ARB_EN
                        r_last_cpl <= 1'b0;
`endif
                    end
                end
                ST_SEND: begin
                    if (s_axis_tx_tready) begin
                        r_tvalid <= 1'b0;
                        if (r_cur_cpl) begin
                            r_compl_done <= 1'b1;
                        end else begin
                            r_tag_alloc_valid <= 1'b1;
                            r_tag_alloc_tag   <= r_cur_tag;
                            r_tag_alloc_len   <= r_cur_len;
                            r_dma_read_done   <= r_cur_last;
                        end
                        r_state <= (r_rem != 11'd0) ? ST_SPLIT : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_axis_tx_tdata  = r_tdata;
    assign s_axis_tx_tkeep  = r_tkeep;
    assign s_axis_tx_tvalid = r_tvalid;
    assign s_axis_tx_tlast  = 1'b1;
    assign tx_src_dsc       = 1'b0;
    assign compl_done       = r_compl_done;
    assign tag_alloc_valid  = r_tag_alloc_valid;
    assign tag_alloc_tag    = r_tag_alloc_tag;
    assign tag_alloc_len    = r_tag_alloc_len;
    assign dma_read_done    = r_dma_read_done;
    assign tags_in_flight   = w_popcount;

endmodule

// File: tb/tb_xilinx_pcie_tx_engine.sv
// tb/tb_xilinx_pcie_tx_engine.sv - directed self-checking bench for xilinx_pcie_tx_engine
module tb_xilinx_pcie_tx_engine;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         s_axis_tx_tready;
    logic [127:0] s_axis_tx_tdata;
    logic [15:0]  s_axis_tx_tkeep;
    logic         s_axis_tx_tlast;
    logic         s_axis_tx_tvalid;
    logic         tx_src_dsc;
    logic [15:0]  completer_id;
    logic [63:0]  dma_read_addr;
    logic [10:0]  dma_read_len;
    logic         dma_read_valid;
    logic         dma_read_ready;
    logic         dma_read_done;
    logic         tag_alloc_valid;
    logic [7:0]   tag_alloc_tag;
    logic [9:0]   tag_alloc_len;
    logic         tag_release_valid;
    logic [7:0]   tag_release_tag;
    logic [8:0]   tags_in_flight;
    logic         req_compl;
    logic         req_compl_wd;
    logic [2:0]   req_tc;
    logic         req_td;
    logic         req_ep;
    logic [1:0]   req_attr;
    logic [9:0]   req_len;
    logic [15:0]  req_rid;
    logic [7:0]   req_tag;
    logic [7:0]   req_be;
    logic [31:0]  req_addr;
    logic [31:0]  rd_addr;
    logic [3:0]   rd_be;
    logic [31:0]  rd_data;
    logic         compl_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    xilinx_pcie_tx_engine #(
        .P_DATA_WIDTH (128),
        .P_NUM_TAGS   (4),
        .P_MRRS_BYTES (512)
    ) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .s_axis_tx_tready  (s_axis_tx_tready),
        .s_axis_tx_tdata   (s_axis_tx_tdata),
        .s_axis_tx_tkeep   (s_axis_tx_tkeep),
        .s_axis_tx_tlast   (s_axis_tx_tlast),
        .s_axis_tx_tvalid  (s_axis_tx_tvalid),
        .tx_src_dsc        (tx_src_dsc),
        .completer_id      (completer_id),
        .dma_read_addr     (dma_read_addr),
        .dma_read_len      (dma_read_len),
        .dma_read_valid    (dma_read_valid),
        .dma_read_ready    (dma_read_ready),
        .dma_read_done     (dma_read_done),
        .tag_alloc_valid   (tag_alloc_valid),
        .tag_alloc_tag     (tag_alloc_tag),
        .tag_alloc_len     (tag_alloc_len),
        .tag_release_valid (tag_release_valid),
        .tag_release_tag   (tag_release_tag),
        .tags_in_flight    (tags_in_flight),
        .req_compl         (req_compl),
        .req_compl_wd      (req_compl_wd),
        .req_tc            (req_tc),
        .req_td            (req_td),
        .req_ep            (req_ep),
        .req_attr          (req_attr),
        .req_len           (req_len),
        .req_rid           (req_rid),
        .req_tag           (req_tag),
        .req_be            (req_be),
        .req_addr          (req_addr),
        .rd_addr           (rd_addr),
        .rd_be             (rd_be),
        .rd_data           (rd_data),
        .compl_done        (compl_done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tvalid(input string tag);
        int n;
        n = 0;
        while (s_axis_tx_tvalid !== 1'b1 && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        chk(tag, 128'(s_axis_tx_tvalid), 128'd1);
    endtask

    // Wait for one MRd beat (tready high), check it, then check the alloc pulse.
    task automatic expect_mrd(input string tag, input logic [127:0] exp_data,
                              input logic [15:0] exp_keep, input logic [7:0] exp_tag,
                              input logic [9:0] exp_len, input logic exp_done);
        wait_tvalid({tag, "_tvalid"});
        chk({tag, "_tdata"}, s_axis_tx_tdata, exp_data);
        chk({tag, "_tkeep"}, 128'(s_axis_tx_tkeep), 128'(exp_keep));
        @(negedge i_clk);
        chk({tag, "_alloc"}, 128'({tag_alloc_valid, tag_alloc_tag, tag_alloc_len, dma_read_done}),
            128'({1'b1, exp_tag, exp_len, exp_done}));
    endtask

    initial begin
        logic [127:0] snap;
        logic [2:0]   ev;
        int           ev_cnt;
        int           bad;
        int           n;
        logic         pend;

        i_rst_n = 1'b0;
        s_axis_tx_tready = 1'b1;
        completer_id = 16'h0100;
        dma_read_addr = '0; dma_read_len = '0; dma_read_valid = 1'b0;
        tag_release_valid = 1'b0; tag_release_tag = '0;
        req_compl = 1'b0; req_compl_wd = 1'b0; req_tc = '0; req_td = 1'b0; req_ep = 1'b0;
        req_attr = '0; req_len = '0; req_rid = '0; req_tag = '0; req_be = '0; req_addr = '0;
        rd_data = '0;

        // Reset state
        repeat (2) @(negedge i_clk);
        chk("rst_tvalid", 128'(s_axis_tx_tvalid), 128'd0);
        chk("rst_ready", 128'(dma_read_ready), 128'd0);
        chk("rst_tags", 128'(tags_in_flight), 128'd0);
        chk("rst_pulses", 128'({tag_alloc_valid, compl_done, dma_read_done}), 128'd0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // CplD, be=1100, addr=0x1234: byte_count 2, lower_addr 0x36
        req_compl = 1'b1; req_compl_wd = 1'b1; req_be = 8'h0C; req_addr = 32'h0000_1234;
        req_len = 10'd1; req_rid = 16'hABCD; req_tag = 8'h05; rd_data = 32'hDEAD_BEEF;
        s_axis_tx_tready = 1'b0;
        @(negedge i_clk);
        chk("cpld_tvalid", 128'(s_axis_tx_tvalid), 128'd1);
        chk("cpld_tdata", s_axis_tx_tdata, 128'hDEADBEEF_ABCD0536_01000002_4A000001);
        chk("cpld_tkeep", 128'(s_axis_tx_tkeep), 128'hFFFF);
        chk("cpld_rd_if", 128'({rd_addr, rd_be}), 128'({32'h0000_1234, 4'hC}));
        s_axis_tx_tready = 1'b1;
        @(negedge i_clk);
        chk("cpld_done", 128'({compl_done, s_axis_tx_tvalid}), 128'b10);
        req_compl = 1'b0;
        @(negedge i_clk);
        chk("cpld_done_1cyc", 128'(compl_done), 128'd0);

        // Cpl without data
        req_compl = 1'b1; req_compl_wd = 1'b0;
        @(negedge i_clk);
        chk("cpl_tdata", s_axis_tx_tdata, 128'h00000000_ABCD0500_01000002_0A000000);
        chk("cpl_tkeep", 128'(s_axis_tx_tkeep), 128'h0FFF);
        req_compl = 1'b0;
        @(negedge i_clk);
        chk("cpl_done", 128'(compl_done), 128'd1);

        // DMA 0xF00 / 256 DW with MRRS 512 -> three MRd32 chunks
        dma_read_addr = 64'h0000_0000_0000_0F00; dma_read_len = 11'd256; dma_read_valid = 1'b1;
        chk("dma_ready_idle", 128'(dma_read_ready), 128'd1);
        @(negedge i_clk);
        dma_read_valid = 1'b0;
        expect_mrd("mrd_c0", 128'h00000000_00000F00_010000FF_00000040, 16'h0FFF, 8'd0, 10'd64, 1'b0);
        expect_mrd("mrd_c1", 128'h00000000_00001000_010001FF_00000080, 16'h0FFF, 8'd1, 10'd128, 1'b0);
        expect_mrd("mrd_c2", 128'h00000000_00001200_010002FF_00000040, 16'h0FFF, 8'd2, 10'd64, 1'b1);
        chk("tags_after_split", 128'(tags_in_flight), 128'd3);

        // MRd64, len 1: last BE 0, first BE F
        dma_read_addr = 64'h0000_0001_0000_0000; dma_read_len = 11'd1; dma_read_valid = 1'b1;
        @(negedge i_clk);
        dma_read_valid = 1'b0;
        expect_mrd("mrd64", 128'h00000000_00000001_0100030F_20000001, 16'hFFFF, 8'd3, 10'd1, 1'b1);
        chk("tags_full", 128'(tags_in_flight), 128'd4);

        // Tag exhaustion stall, ignored out-of-range release, release of tag 2
        dma_read_addr = 64'h0000_0000_0000_2000; dma_read_len = 11'd4; dma_read_valid = 1'b1;
        @(negedge i_clk);
        dma_read_valid = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("stall_no_tlp", 128'({s_axis_tx_tvalid, dma_read_ready}), 128'd0);
        tag_release_valid = 1'b1; tag_release_tag = 8'd200;
        @(negedge i_clk);
        tag_release_valid = 1'b0;
        @(negedge i_clk);
        chk("rel_out_of_range", 128'({s_axis_tx_tvalid, tags_in_flight}), 128'({1'b0, 9'd4}));
        s_axis_tx_tready = 1'b0;
        tag_release_valid = 1'b1; tag_release_tag = 8'd2;
        @(negedge i_clk);
        tag_release_valid = 1'b0;
        chk("rel_cleared", 128'({s_axis_tx_tvalid, tags_in_flight}), 128'({1'b0, 9'd3}));
        @(negedge i_clk);
        chk("rel_realloc_valid", 128'({s_axis_tx_tvalid, tags_in_flight}), 128'({1'b1, 9'd4}));
        chk("rel_realloc_tdata", s_axis_tx_tdata, 128'h00000000_00002000_010002FF_00000004);

        // tready low for 10 cycles: beat held, no alloc pulse
        snap = s_axis_tx_tdata;
        bad = 0;
        repeat (10) begin
            @(negedge i_clk);
            if (s_axis_tx_tdata !== snap || s_axis_tx_tvalid !== 1'b1 ||
                s_axis_tx_tkeep !== 16'h0FFF || tag_alloc_valid !== 1'b0)
                bad++;
        end
        chk("hold_stable", 128'(bad), 128'd0);
        s_axis_tx_tready = 1'b1;
        @(negedge i_clk);
        chk("hold_release", 128'({tag_alloc_valid, tag_alloc_tag, tag_alloc_len, dma_read_done, s_axis_tx_tvalid}),
            128'({1'b1, 8'd2, 10'd4, 1'b1, 1'b0}));
        @(negedge i_clk);
        chk("hold_one_tlp", 128'({s_axis_tx_tvalid, tag_alloc_valid}), 128'd0);

        // Reset asserted mid-SEND
        req_compl = 1'b1; req_compl_wd = 1'b1; s_axis_tx_tready = 1'b0;
        @(negedge i_clk);
        chk("pre_rst_send", 128'(s_axis_tx_tvalid), 128'd1);
        i_rst_n = 1'b0;
        req_compl = 1'b0;
        #1;
        chk("mid_rst", 128'({s_axis_tx_tvalid, tags_in_flight}), 128'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        s_axis_tx_tready = 1'b1;
        repeat (2) @(negedge i_clk);

        // Continuous req_compl with a DMA descriptor pending
        req_compl = 1'b1; req_compl_wd = 1'b1;
        dma_read_addr = 64'h0000_0000_0000_3000; dma_read_len = 11'd8; dma_read_valid = 1'b1;
        ev = '0; ev_cnt = 0; pend = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge i_clk);
            if (pend) dma_read_valid = 1'b0;
            pend = dma_read_valid & dma_read_ready;
            if (compl_done || tag_alloc_valid) begin
                if (ev_cnt < 3) ev[2'(ev_cnt)] = tag_alloc_valid;
                ev_cnt++;
            end
        end
        chk("arb_events", 128'(ev_cnt >= 3), 128'd1);
`ifdef PCIE_TX_RR_ARB_EN
        chk("arb_rr_order", 128'(ev), 128'b010);
        req_compl = 1'b0;
`else
        chk("arb_strict_order", 128'(ev), 128'b000);
        req_compl = 1'b0;
        n = 0;
        while (tag_alloc_valid !== 1'b1 && n < 30) begin
            @(negedge i_clk);
            if (pend) dma_read_valid = 1'b0;
            pend = dma_read_valid & dma_read_ready;
            n++;
        end
        chk("arb_strict_dma_after", 128'({tag_alloc_valid, tag_alloc_tag, tag_alloc_len}),
            128'({1'b1, 8'd0, 10'd8}));
`endif
        dma_read_valid = 1'b0;
        repeat (2) @(negedge i_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xilinx_pcie_tx_engine.md
Name: xilinx_pcie_tx_engine

Overview:
- Parametrised successor to the single-beat PCIe TX TLP builder on the 128-bit Xilinx AXIS TX interface.
- Arbitrates PIO completions (Cpl/CplD) against DMA memory read requests.
- Splits DMA reads into MRRS-aligned chunks, emits MRd32 or MRd64 as the address requires, and manages a pool of outstanding read tags.
- Sits between the PIO/DMA control logic and the PCIe core TX port.

Parameters:
- P_DATA_WIDTH, 128, AXIS data width; only 128 is supported.
- P_KEEP_WIDTH, P_DATA_WIDTH/8, tkeep width.
- P_NUM_TAGS, 32, outstanding read tags, 1..256; tags 0..P_NUM_TAGS-1.
- P_MRRS_BYTES, 512, max read request bytes; power of two, 128..4096.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- s_axis_tx_tready  in  1  core ready
- s_axis_tx_tdata  out  128  TLP beat
- s_axis_tx_tkeep  out  16  byte enables
- s_axis_tx_tlast  out  1  end of TLP; always 1
- s_axis_tx_tvalid  out  1  beat valid
- tx_src_dsc  out  1  discontinue; tied 0
- completer_id  in  16  own requester/completer ID
- dma_read_addr  in  64  byte address, DW aligned
- dma_read_len  in  11  length in DW, 1..1024
- dma_read_valid  in  1  descriptor valid
- dma_read_ready  out  1  descriptor accepted when valid&ready
- dma_read_done  out  1  1-cycle pulse: last chunk of descriptor sent
- tag_alloc_valid  out  1  1-cycle pulse: MRd sent
- tag_alloc_tag  out  8  tag of that MRd
- tag_alloc_len  out  10  DW length of that MRd
- tag_release_valid  in  1  completion tracker frees a tag
- tag_release_tag  in  8  tag to free
- tags_in_flight  out  9  allocated tag count
- req_compl, req_compl_wd  in  1,1  completion request; with-data flag
- req_tc, req_td, req_ep, req_attr, req_len, req_rid, req_tag, req_be, req_addr  in  3,1,1,2,10,16,8,8,32  request fields
- rd_addr  out  32  = req_addr
- rd_be  out  4  = req_be[3:0]
- rd_data  in  32  completion payload
- compl_done  out  1  1-cycle pulse on completion handshake

Behaviour:
- Reset: all outputs 0, state IDLE, tag bitmap cleared, split registers cleared. A reset mid-TLP drops the beat and any partial descriptor.
- States: IDLE, SPLIT, SEND.
- IDLE, descriptor path: dma_read_ready=1 only in IDLE with no req_compl pending, or when the arbiter grants DMA. On accept, latch addr/len and go to SPLIT.
- Chunk length: min(remaining, (P_MRRS_BYTES - addr mod P_MRRS_BYTES)/4) DW. A len field of 1024 is encoded as 0.
- SPLIT: waits until a free tag exists (tags_in_flight < P_NUM_TAGS).
  - Allocates the lowest free tag.
  - Loads the header, asserts tvalid next cycle, goes to SEND.
  - The arbiter may interleave a pending completion between chunks.
- MRd header:
  - addr[63:32]==0: fmt_type 7'b00_00000, 3DW, tkeep 0x0FFF.
  - Otherwise: 7'b01_00000, 4DW with upper address in DW2, tkeep 0xFFFF.
  - Requester ID = completer_id; TC/attr/TD/EP = 0.
  - First BE = F. Last BE = F if len>1, else 0.
- Completion: CplD 7'b10_01010 with tkeep 0xFFFF and rd_data in DW3; Cpl 7'b00_01010 with tkeep 0x0FFF.
  - byte_count derived from rd_be.
  - lower_addr = {req_addr[6:2], offset of first enabled byte}; 0 for Cpl.
- SEND: tdata/tkeep/tvalid held stable until tready. On handshake:
  - Drop tvalid and pulse compl_done, or pulse tag_alloc_* (plus dma_read_done if last chunk).
  - Then SPLIT if chunks remain, else IDLE.
- Latency: request/grant at cycle N gives tvalid at N+1. Minimum 2 cycles per TLP.
- Tag release:
  - Clears the bitmap bit. Release of an unallocated or out-of-range tag is ignored.
  - Same-cycle allocate and release: both apply. The released tag becomes allocatable the next cycle.
  - tags_in_flight equals the bitmap popcount at all times.
- Address arithmetic: addr advances by chunk*4 per chunk, 64-bit carry. The MRRS boundary split also guarantees no 4KB crossing.

Optional Feature:
- PCIE_TX_RR_ARB_EN defined: round-robin between completion and DMA sources. The last granted source has lowest priority next arbitration.
- Undefined: completions have strict priority. A DMA chunk is issued only when req_compl=0.

Test Plan:
- Completion with data, req_be=4'b1100, req_addr=0x1234 → CplD, byte_count=2, lower_addr=0x36, tkeep 0xFFFF, compl_done 1 cycle after handshake.
- DMA read addr=0x0000_0000_0000_0F00, len=256 DW, MRRS 512 → 3 MRd32: len 64 @0xF00, len 128 @0x1000, len 64 @0x1200; tags 0,1,2; dma_read_done with the third.
- addr=0x1_0000_0000, len=1 → MRd64, tkeep 0xFFFF, last BE 0, first BE F.
- P_NUM_TAGS=4, 6 single-chunk reads, no releases → 4 MRd sent then stall. Release tag 2 → next MRd uses tag 2 one cycle later.
- tready held low 10 cycles during SEND → tdata/tkeep stable, one TLP only. Assert i_rst_n=0 mid-SEND → tvalid 0 immediately, tags_in_flight 0.
- Continuous req_compl with DMA pending → with PCIE_TX_RR_ARB_EN alternating TLPs; without it DMA is starved until req_compl drops.
